// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default widths, reset PC and the
// instruction field layout used by fetch and later decode stages.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 16;
  localparam logic [7:0] RESET_PC = 8'h00;

  // Instruction field positions (MSB/LSB of each 4-bit field).
  localparam int OPCODE_HI = 15;
  localparam int OPCODE_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_fields_t;

  // Split a raw instruction word into its named fields.
  function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_HI:OPCODE_LO];
    f.rd = instr[RD_HI:RD_LO];
    f.rs1 = instr[RS1_HI:RS1_LO];
    f.rs2 = instr[RS2_HI:RS2_LO];
    return f;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry show-ahead queue of {pc, instr} pairs between fetch and decode.
// The head entry is visible on head_* whenever count != 0; flush empties
// the queue in one edge and wins over any push/pop on that edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int IW = INSTR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] push_pc,
  input  logic [IW-1:0] push_instr,
  input  logic          pop,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_instr,
  output logic [1:0]    count
);

  logic [AW-1:0] pc_mem [2];
  logic [IW-1:0] instr_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_pop;
  logic          do_push;

  // A pop on an empty queue is ignored; a push into a full queue is only
  // taken when the head leaves on the same edge.
  assign do_pop = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  assign head_pc = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Storage, pointers and occupancy; reset clears storage so head_* read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_mem[0] <= '0;
      pc_mem[1] <= '0;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr] <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, fetch/redirect/halt control and the queue
// feeding decode.
//
// Decode handshake: id_valid means the head entry on id_pc/id_instr is
// valid; the entry is consumed on a rising edge where id_valid && id_ready.
// While id_valid && !id_ready the head holds stable unless a redirect
// flushes the queue.
module fetch_unit #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [1:0]         q_count
);
  import fetch_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic              pop;
  logic              fetch;

  assign imem_addr = pc;
  assign id_valid = (q_count != 2'd0);
  assign pop = id_valid && id_ready;
  // Fetch only when there is room now or the head leaves this edge;
  // a redirect or halt suppresses the fetch.
  assign fetch = !halt && !redirect_valid && ((q_count != 2'd2) || pop);

  // PC update: redirect target first, otherwise sequential on a fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_addr;
    end else if (fetch) begin
      pc <= pc + 1'b1;
    end
  end

  fetch_queue #(
    .AW(ADDR_W),
    .IW(INSTR_W)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (fetch),
    .push_pc    (pc),
    .push_instr (imem_instr),
    .pop        (pop),
    .head_pc    (id_pc),
    .head_instr (id_instr),
    .count      (q_count)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter INSTR_W, default 16, instruction width.
REQ-003 Parameter RESET_PC, default 8'h00, PC value loaded at reset.
REQ-004 Timing and reset SHALL be as follows: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 imem_addr  out  ADDR_W  address to instruction memory, equal to the current PC.
REQ-008 imem_instr  in  INSTR_W  instruction returned combinationally for imem_addr.
REQ-009 redirect_valid  in  1  branch/jump redirect request.
REQ-010 redirect_addr  in  ADDR_W  redirect target PC.
REQ-011 halt  in  1  suspend fetching while high.
REQ-012 id_valid  out  1  head entry available to decode.
REQ-013 id_ready  in  1  decode accepts the head entry this cycle.
REQ-014 id_instr  out  INSTR_W  head-entry instruction.
REQ-015 id_pc  out  ADDR_W  head-entry PC.
REQ-016 q_count  out  2  occupancy of the fetch queue (0..2).

Function
REQ-017 imem_addr SHALL be driven combinationally from the PC register.
REQ-018 The block SHALL contain a 2-entry show-ahead FIFO of {pc, instr} pairs; id_valid = (q_count != 0); id_instr and id_pc = head entry.
REQ-019 A pop SHALL occur when id_valid && id_ready.
REQ-020 A fetch SHALL occur when !halt && !redirect_valid && (q_count < 2 || pop); a fetch pushes {PC, imem_instr} and sets PC <= PC + 1.
REQ-021 PC increment SHALL be modulo 2^ADDR_W: 8'hFF wraps to 8'h00.
REQ-022 Latency: an instruction fetched at edge N SHALL appear on id_* after edge N, i.e. in cycle N+1, when the queue was empty.
REQ-023 Simultaneous push and pop SHALL be supported; q_count is unchanged and entry order is preserved.
REQ-024 Full (q_count = 2) with no pop: no fetch; PC, imem_addr, and id_* SHALL hold stable.
REQ-025 Redirect: on an edge with redirect_valid = 1, the queue SHALL be flushed (q_count <= 0), PC <= redirect_addr, and no push occurs; a same-cycle pop counts as accepted by decode.
REQ-026 After a redirect at edge N, imem_addr = redirect_addr in cycle N+1, and the target instruction appears on id_* in cycle N+2.
REQ-027 Halt: no fetch, PC holds, and the queue continues to drain through pops.
REQ-028 Redirect SHALL take priority over halt when both are asserted.
REQ-029 id_* SHALL NOT change while id_valid && !id_ready, unless a redirect occurs.

Reset
REQ-030 While rst is high: PC = RESET_PC, q_count = 0, FIFO pointers = 0, all FIFO storage = 0; hence id_valid = 0, id_instr = 0, id_pc = 0, and imem_addr = RESET_PC.
REQ-031 Reset assertion SHALL take effect immediately without a clock edge and SHALL discard any queued entries mid-operation.
REQ-032 The first fetch SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-033 Shared package fetch_pkg SHALL hold ADDR_W, INSTR_W, RESET_PC, and the instruction field positions: opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0].
REQ-034 The FIFO SHALL be a sub-module fetch_queue (2-entry, with flush input, push/pop, show-ahead output, and count).
REQ-035 fetch_unit SHALL contain only the PC register, the fetch/redirect/halt control, and the fetch_queue instance.

Verification
REQ-036 Memory holds [0]=16'h0123 and [1]=16'h1456; release reset with id_ready=1 -> cycle 1: id_valid=1, id_pc=0, id_instr=16'h0123; cycle 2: id_pc=1, id_instr=16'h1456.
REQ-037 id_ready=0 after reset -> q_count reaches 2 after 2 edges, imem_addr holds 2, and id_pc stays 0; raise id_ready -> id_pc sequence is 0, 1, 2, 3 on consecutive cycles.
REQ-038 Queue holds PCs 3 and 4; pulse redirect_valid with redirect_addr=8'h05 -> next cycle: id_valid=0, q_count=0, imem_addr=5; following cycle: id_pc=5.
REQ-039 Redirect to 8'hFF with id_ready=1 -> id_pc sequence is 8'hFF, 8'h00, 8'h01.
REQ-040 halt=1 for 3 cycles with a full queue and id_ready=1 -> queue drains to 0, imem_addr stays frozen, and id_valid=0; halt and redirect to 8'h10 in the same cycle -> imem_addr=8'h10.
REQ-041 Assert rst asynchronously with q_count=2 -> id_valid=0, id_pc=0, and imem_addr=RESET_PC before the next clock edge.
